mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address and data width of the shared memory port.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports m0_req/m1_req, input, 1 each: requester 0 (SPU core) and requester 1 (DMA/loader) access request.
REQ-005 SHALL have ports m0_we/m1_we, input, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have ports m0_adr/m1_adr and m0_wdata/m1_wdata, input, WIDTH each: address and write data.
REQ-007 SHALL have port m1_lock, input, 1: requester 1 holds priority while asserted with m1_req.
REQ-008 SHALL have ports m0_ack/m1_ack, output, 1 each: one-cycle completion pulse.
REQ-009 SHALL have ports m0_rdata/m1_rdata, output, WIDTH each: read data, valid while the matching ack is high and held until that requester's next read completes.
REQ-010 SHALL have ports memread and memwrite, output, 1 each: memory strobes.
REQ-011 SHALL have ports adr and writedata, output, WIDTH each: memory address and write data.
REQ-012 SHALL have port memdata, input, WIDTH: memory read data, valid the cycle after the strobe cycle.
REQ-013 SHALL have ports grant, output, 2 (one-hot: bit0 = m0, bit1 = m1), and busy, output, 1 (state != IDLE).

Function
REQ-014 SHALL implement states IDLE, ACCESS, CAPTURE, ACK, in a fixed sequence IDLE->ACCESS->CAPTURE->ACK->IDLE.
REQ-015 IDLE: if any req is high at a clock edge, SHALL select a winner, latch its we/adr/wdata, set grant, and enter ACCESS; otherwise SHALL stay in IDLE.
REQ-016 ACCESS: for exactly one cycle, SHALL drive adr/writedata from the latched values and assert memread (we=0) or memwrite (we=1).
REQ-017 CAPTURE: strobes low; on a read, SHALL register memdata into the winner's rdata at the closing edge.
REQ-018 ACK: SHALL pulse the winner's ack for exactly one cycle, then return to IDLE; grant SHALL clear on entry to IDLE.
REQ-019 Latency: req sampled at edge E0 -> strobe cycle E0-E1 -> ack cycle E2-E3; at most one transfer per 4 cycles.
REQ-020 Requesters SHALL hold req/we/adr/wdata stable until ack and drop req in the ack cycle; the arbiter samples only latched copies after IDLE.
REQ-021 Arbitration for single request: grant that requester.
REQ-022 Arbitration for simultaneous requests: if m1_lock = 1, grant m1; else grant the requester not granted last (round robin).
REQ-023 A last-grant flag SHALL update on every grant.
REQ-024 A locked m1 grant SHALL still update the last-grant flag, so m0 wins the first tie after lock drops.
REQ-025 A req arriving mid-transaction SHALL wait and be arbitrated at the next IDLE edge; no request is lost or reordered.
REQ-026 When not in ACCESS, memread and memwrite SHALL be 0; adr/writedata SHALL hold their last values.
REQ-027 Both strobes SHALL never be high together, and both acks SHALL never be high together.

Reset
REQ-028 On reset low, asynchronously: state=IDLE, grant=00, busy=0, memread=memwrite=0, m0_ack=m1_ack=0.
REQ-029 On reset low, asynchronously: adr=writedata=0, m0_rdata=m1_rdata=0, last-grant flag=m1 (so m0 wins the first tie).
REQ-030 Reset asserted mid-transaction SHALL abort it: the strobe drops immediately, no ack is issued, and no rdata is updated.
REQ-031 After reset release, the first IDLE edge SHALL arbitrate normally.

Verification
REQ-032 Scenario, m0 write: m0 write adr=5 wdata=7 -> memwrite=1, adr=5, writedata=7 for exactly one cycle; m0_ack 2 cycles later; memory[5]=7.
REQ-033 Scenario, m1 read: m1 read adr=5 after that write -> memread one cycle; m1_rdata=7 with m1_ack; m0_ack stays 0.
REQ-034 Scenario, round robin: m0 and m1 both request continuously, lock=0 -> grants alternate m0,m1,m0,m1 starting with m0, one ack per 4 cycles.
REQ-035 Scenario, lock: m1_lock=1 with both requesting for 3 transfers -> three m1 grants; after lock drops, next grant is m0.
REQ-036 Scenario, reset mid-op: reset low during ACCESS of a write -> strobes 0 immediately, no ack; after release, state IDLE and outputs at reset values.
REQ-037 Scenario, idle hold: no requests for 10 cycles -> busy=0, strobes 0, grant=00 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for a shared single-port memory
module mem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m0_we,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m0_adr,
  input  logic [WIDTH-1:0] m1_adr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic             m1_lock,
  output logic             m0_ack,
  output logic             m1_ack,
  output logic [WIDTH-1:0] m0_rdata,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata,
  output logic [1:0]       grant,
  output logic             busy
);

  // Every transfer walks the same four states; strobes and acks decode from them.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_m1_q, last_m1_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic             pick_m1;

  // Winner selection: a lone requester wins; a tie goes to a locked m1,
  // otherwise to whichever requester was not served last.
  always_comb begin
    pick_m1 = 1'b0;
    if (m0_req && m1_req) begin
      pick_m1 = m1_lock ? 1'b1 : ~last_m1_q;
    end else begin
      pick_m1 = m1_req;
    end
  end

  // Next-state and datapath updates; the requester inputs are only looked
  // at in IDLE, afterwards the latched copies drive the memory port.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_m1_d  = last_m1_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d   = S_ACCESS;
          grant_d   = pick_m1 ? 2'b10 : 2'b01;
          last_m1_d = pick_m1;
          we_d      = pick_m1 ? m1_we    : m0_we;
          adr_d     = pick_m1 ? m1_adr   : m0_adr;
          wdata_d   = pick_m1 ? m1_wdata : m0_wdata;
        end
      end
      S_ACCESS: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_ACK;
        // memdata is valid in this cycle only, one cycle after the read strobe
        if (!we_q) begin
          if (grant_q[1]) begin
            m1_rdata_d = memdata;
          end else if (grant_q[0]) begin
            m0_rdata_d = memdata;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight and
  // leaves last-grant pointing at m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      last_m1_q  <= 1'b1;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_m1_q  <= last_m1_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Strobes and acks decode straight from state so reset drops them at once;
  // the one-hot grant keeps the two acks mutually exclusive.
  always_comb begin
    memread   = (state_q == S_ACCESS) && !we_q;
    memwrite  = (state_q == S_ACCESS) && we_q;
    m0_ack    = (state_q == S_ACK) && grant_q[0];
    m1_ack    = (state_q == S_ACK) && grant_q[1];
    busy      = (state_q != S_IDLE);
    grant     = grant_q;
    adr       = adr_q;
    writedata = wdata_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m1_req, m0_we, m1_we, m1_lock;
  logic [31:0] m0_adr, m1_adr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, memread, memwrite, busy;
  logic [31:0] m0_rdata, m1_rdata, adr, writedata, memdata;
  logic [1:0]  grant;
  logic        mem_clr;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_adr(m0_adr), .m1_adr(m1_adr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .memread(memread), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .memdata(memdata), .grant(grant), .busy(busy)
  );

  // Memory device: 16 words, read data registered one cycle after the strobe.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (memwrite) begin
      mem[adr[3:0]] <= writedata;
    end
    memdata <= memread ? mem[adr[3:0]] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m1_lock = 0;
    m0_adr = 0; m1_adr = 0; m0_wdata = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 0;
    mem_clr = 1;
    @(negedge clk);
    @(negedge clk);
    mem_clr = 0;
    reset_n = 1;
  endtask

  typedef struct {
    logic        r0, r1, lock, we0, we1;
    logic [31:0] a0, a1, d0, d1;
    logic        win1;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [11];

  // Random-phase reference model: transaction level, per-cycle phase counter.
  int          phase;
  logic        model_last1, cur_w1, cur_we, can_grant;
  logic [31:0] cur_a, cur_d;
  logic [31:0] ref_mem [16];
  logic [31:0] exp_rd [2];

  initial begin
    logic w_we;
    logic [31:0] w_a, w_d;
    reset_n = 0;
    mem_clr = 1;
    idle_inputs();

    // reset values
    #2;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_grant", {30'h0, grant}, 0);
    chk("rst_strobes", {30'h0, memread, memwrite}, 0);
    chk("rst_acks", {30'h0, m0_ack, m1_ack}, 0);
    chk("rst_adr", adr, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    mem_clr = 0;
    reset_n = 1;

    // idle hold
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'h0, busy}, 0);
      chk("idle_strobes", {30'h0, memread, memwrite}, 0);
      chk("idle_grant", {30'h0, grant}, 0);
    end

    //           r0 r1 lk we0 we1 a0 a1 d0     d1     win1 rd
    tbl[0]  = '{1, 0, 0, 1, 0, 5, 0, 7,     0,     0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 5, 0,     0,     1, 7};
    tbl[2]  = '{1, 1, 0, 1, 1, 3, 4, 'h11,  'h22,  0, 0};
    tbl[3]  = '{1, 1, 0, 1, 1, 3, 4, 'h11,  'h22,  1, 0};
    tbl[4]  = '{1, 1, 1, 0, 0, 4, 3, 0,     0,     1, 'h11};
    tbl[5]  = '{1, 1, 1, 0, 0, 4, 3, 0,     0,     1, 'h11};
    tbl[6]  = '{1, 1, 1, 0, 0, 4, 3, 0,     0,     1, 'h11};
    tbl[7]  = '{1, 1, 0, 0, 0, 4, 3, 0,     0,     0, 'h22};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 5, 0,     0,     1, 7};
    tbl[9]  = '{1, 0, 0, 0, 0, 3, 0, 0,     0,     0, 'h11};
    tbl[10] = '{1, 1, 0, 0, 1, 4, 9, 0,     'hAB,  1, 0};

    for (int r = 0; r < 11; r++) begin
      @(negedge clk);
      m0_req = tbl[r].r0; m1_req = tbl[r].r1; m1_lock = tbl[r].lock;
      m0_we = tbl[r].we0; m1_we = tbl[r].we1;
      m0_adr = tbl[r].a0; m1_adr = tbl[r].a1;
      m0_wdata = tbl[r].d0; m1_wdata = tbl[r].d1;
      w_we = tbl[r].win1 ? tbl[r].we1 : tbl[r].we0;
      w_a  = tbl[r].win1 ? tbl[r].a1 : tbl[r].a0;
      w_d  = tbl[r].win1 ? tbl[r].d1 : tbl[r].d0;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", r), {30'h0, grant}, tbl[r].win1 ? 2'b10 : 2'b01);
      chk($sformatf("tbl%0d_strobe", r), {30'h0, memread, memwrite}, w_we ? 2'b01 : 2'b10);
      chk($sformatf("tbl%0d_adr", r), adr, w_a);
      if (w_we) chk($sformatf("tbl%0d_wdata", r), writedata, w_d);
      @(negedge clk);
      chk($sformatf("tbl%0d_strobe_off", r), {30'h0, memread, memwrite}, 0);
      chk($sformatf("tbl%0d_early_ack", r), {30'h0, m0_ack, m1_ack}, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_acks", r), {30'h0, m1_ack, m0_ack}, tbl[r].win1 ? 2'b10 : 2'b01);
      if (!w_we) chk($sformatf("tbl%0d_rdata", r), tbl[r].win1 ? m1_rdata : m0_rdata, tbl[r].rd);
      m0_req = 0; m1_req = 0;
    end
    chk("tbl_mem9", mem[9], 32'hAB);

    // reset during the strobe cycle of a write
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_adr = 6; m0_wdata = 32'h55; m1_lock = 0;
    @(negedge clk);
    chk("rmid_strobe_seen", {31'h0, memwrite}, 1);
    #1 reset_n = 0;
    #1;
    chk("rmid_strobe_drop", {30'h0, memread, memwrite}, 0);
    chk("rmid_busy", {31'h0, busy}, 0);
    chk("rmid_grant", {30'h0, grant}, 0);
    chk("rmid_adr", adr, 0);
    chk("rmid_wdata", writedata, 0);
    m0_req = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rmid_ack_in_reset", {30'h0, m0_ack, m1_ack}, 0);
    end
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rmid_ack_after", {30'h0, m0_ack, m1_ack}, 0);
      chk("rmid_busy_after", {31'h0, busy}, 0);
      chk("rmid_rdata", m0_rdata | m1_rdata, 0);
    end
    chk("rmid_no_write", mem[6], 0);

    // round robin with both requesting continuously
    do_reset();
    @(negedge clk);
    m0_req = 1; m1_req = 1; m0_adr = 1; m1_adr = 2;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("rr_ack0_c%0d", i), {31'h0, m0_ack}, (i % 8 == 3) ? 1 : 0);
      chk($sformatf("rr_ack1_c%0d", i), {31'h0, m1_ack}, (i % 8 == 7) ? 1 : 0);
    end

    // randomized traffic against the transaction model
    do_reset();
    phase = 0;
    model_last1 = 1;
    exp_rd[0] = 0; exp_rd[1] = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      can_grant = (phase == 0);
      chk("rnd_excl", {31'h0, (m0_ack & m1_ack) | (memread & memwrite)}, 0);
      case (phase)
        0: begin
          chk("rnd_idle", {27'h0, busy, grant, memread, memwrite}, 0);
          chk("rnd_idle_ack", {30'h0, m0_ack, m1_ack}, 0);
        end
        1: begin
          chk("rnd_grant", {30'h0, grant}, cur_w1 ? 2'b10 : 2'b01);
          chk("rnd_strobe", {30'h0, memread, memwrite}, cur_we ? 2'b01 : 2'b10);
          chk("rnd_adr", adr, cur_a);
          if (cur_we) begin
            chk("rnd_wdata", writedata, cur_d);
            ref_mem[cur_a[3:0]] = cur_d;
          end
        end
        2: chk("rnd_capture", {28'h0, memread, memwrite, m0_ack, m1_ack}, 0);
        default: begin
          chk("rnd_ack", {30'h0, m1_ack, m0_ack}, cur_w1 ? 2'b10 : 2'b01);
          if (!cur_we) exp_rd[cur_w1] = ref_mem[cur_a[3:0]];
        end
      endcase
      chk("rnd_rdata0", m0_rdata, exp_rd[0]);
      chk("rnd_rdata1", m1_rdata, exp_rd[1]);
      phase = (phase == 0) ? 0 : (phase + 1) % 4;

      if (m0_req && m0_ack) m0_req = 0;
      else if (!m0_req && $urandom_range(0, 2) == 0) begin
        m0_req = 1; m0_we = 1'($urandom_range(0, 1));
        m0_adr = $urandom_range(0, 15); m0_wdata = $urandom;
      end
      if (m1_req && m1_ack) m1_req = 0;
      else if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1; m1_we = 1'($urandom_range(0, 1));
        m1_adr = $urandom_range(0, 15); m1_wdata = $urandom;
      end
      m1_lock = ($urandom_range(0, 3) == 0);

      if (can_grant && (m0_req || m1_req)) begin
        if (m0_req && m1_req) cur_w1 = m1_lock ? 1'b1 : !model_last1;
        else cur_w1 = m1_req;
        model_last1 = cur_w1;
        cur_we = cur_w1 ? m1_we : m0_we;
        cur_a  = cur_w1 ? m1_adr : m0_adr;
        cur_d  = cur_w1 ? m1_wdata : m0_wdata;
        phase = 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
